// File: rtl/jelly3_uart_pkg.sv
// Shared types for the jelly3 UART TX arbiter.
// state_t keeps PREFIX in every build so the state encoding does not depend on configuration.
package jelly3_uart_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PREFIX = 2'd1,
      DATA   = 2'd2
   } state_t;

endpackage

// File: rtl/jelly3_rr_picker.sv
// Combinational rotate-priority encoder: first asserted req searching from ptr+1, wrapping modulo NUM.
// Works for any NUM >= 2, including non-powers of two (never yields an index >= NUM).
module jelly3_rr_picker
   import jelly3_uart_pkg::*;
#(
   parameter int NUM        = 4,
   parameter int INDEX_BITS = $clog2(NUM)
)
(
   input  logic [NUM-1:0]        req,
   input  logic [INDEX_BITS-1:0] ptr,
   output logic                  found,
   output logic [INDEX_BITS-1:0] index
);

   int                  w_pos;
   logic [INDEX_BITS-1:0] w_pos_idx;

   always_comb begin
      found     = 1'b0;
      index     = '0;
      w_pos     = 0;
      w_pos_idx = '0;
      for (int i = 1; i <= NUM; i++) begin
         w_pos = int'(ptr) + i;
         if (w_pos >= NUM) begin
            w_pos = w_pos - NUM;
         end
         w_pos_idx = INDEX_BITS'(w_pos);
         if (!found && req[w_pos_idx]) begin
            found = 1'b1;
            index = w_pos_idx;
         end
      end
   end

endmodule

// File: rtl/jelly3_uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART TX byte stream between NUM sources.
// Define JELLY3_UART_TX_ARBITER_PREFIX_EN to emit PREFIX_BASE+grant ahead of every packet.
module jelly3_uart_tx_arbiter
   import jelly3_uart_pkg::*;
#(
   parameter int    NUM          = 4,
   parameter int    INDEX_BITS   = $clog2(NUM),
   parameter int    TIMEOUT_BITS = 16,
   parameter int    TIMEOUT      = 1000,
   parameter byte_t PREFIX_BASE  = 8'h30
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cke,

   input  logic [NUM*8-1:0]      s_data,
   input  logic [NUM-1:0]        s_last,
   input  logic [NUM-1:0]        s_valid,
   output logic [NUM-1:0]        s_ready,

   output logic [7:0]            m_data,
   output logic                  m_valid,
   input  logic                  m_ready,

   output logic [INDEX_BITS-1:0] grant,
   output logic                  busy,
   output logic                  timeout
);

   state_t                  r_state;
   logic [INDEX_BITS-1:0]   r_grant;
   logic [INDEX_BITS-1:0]   r_ptr;
   logic                    r_busy;
   logic                    r_timeout;
   byte_t                   r_m_data;
   logic                    r_m_valid;
   logic [TIMEOUT_BITS-1:0] r_stall;

   byte_t                   w_src_data [NUM];
   byte_t                   w_load_byte;
   logic                    w_load_ok;
   logic                    w_xfer;
   logic                    w_found;
   logic [INDEX_BITS-1:0]   w_index;
   logic [TIMEOUT_BITS-1:0] w_stall_next;
   logic                    w_stall_hit;

   jelly3_rr_picker #(
      .NUM        (NUM),
      .INDEX_BITS (INDEX_BITS)
   ) u_picker (
      .req   (s_valid),
      .ptr   (r_ptr),
      .found (w_found),
      .index (w_index)
   );

   always_comb begin
      for (int i = 0; i < NUM; i++) begin
         w_src_data[i] = s_data[i*8 +: 8];
      end
   end

   // The output register can take a new byte when empty or when its current byte leaves this cycle.
   assign w_load_ok    = !r_m_valid || m_ready;
   assign w_xfer       = (r_state == DATA) && s_valid[r_grant] && w_load_ok;
   assign w_load_byte  = (r_state == PREFIX) ? byte_t'(PREFIX_BASE + byte_t'(r_grant))
                                             : w_src_data[r_grant];
   assign w_stall_next = (&r_stall) ? r_stall : r_stall + 1'b1;
   assign w_stall_hit  = (TIMEOUT != 0) && (w_stall_next >= TIMEOUT_BITS'(TIMEOUT));

   always_comb begin
      s_ready = '0;
      if (r_state == DATA) begin
         s_ready[r_grant] = cke && w_load_ok;
      end
   end

   // NOTE: reset is checked ahead of cke, so a reset always wins and drops any byte held in the output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_grant   <= '0;
         r_ptr     <= INDEX_BITS'(NUM - 1);
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
         r_m_data  <= '0;
         r_m_valid <= 1'b0;
         r_stall   <= '0;
      end else if (cke) begin
         r_timeout <= 1'b0;
         if (r_m_valid && m_ready) begin
            r_m_valid <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_grant <= w_index;
                  r_ptr   <= w_index;
                  r_busy  <= 1'b1;
                  r_stall <= '0;
`ifdef JELLY3_UART_TX_ARBITER_PREFIX_EN
                  r_state <= PREFIX;
`else
                  r_state <= DATA;
`endif
               end
            end

`ifdef JELLY3_UART_TX_ARBITER_PREFIX_EN
            PREFIX: begin
               if (w_load_ok) begin
                  r_m_data  <= w_load_byte;
                  r_m_valid <= 1'b1;
                  r_state   <= DATA;
               end
            end
`endif

            DATA: begin
               if (w_xfer) begin
                  r_m_data  <= w_load_byte;
                  r_m_valid <= 1'b1;
                  r_stall   <= '0;
                  if (s_last[r_grant]) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end else if (!s_valid[r_grant]) begin
                  // Only an absent owner counts as a stall; output backpressure never does.
                  r_stall <= w_stall_next;
                  if (w_stall_hit) begin
                     r_state   <= IDLE;
                     r_busy    <= 1'b0;
                     r_timeout <= 1'b1;
                  end
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign m_data  = r_m_data;
   assign m_valid = r_m_valid;
   assign grant   = r_grant;
   assign busy    = r_busy;
   assign timeout = r_timeout;

endmodule
